// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: XLEN/BITS_PER_CYCLE + 3 cycles from the accept cycle to out_valid; 2 for a special-case divide.
// Backpressure: in_ready only in IDLE; the result and out_valid hold in DONE until out_ready.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        request handshake; op (funct3), a (rs1), b (rs2)
//   flush                    abort any in-flight operation, no result emitted
//   out_valid/out_ready      result handshake; result
//   busy                     unit is not IDLE
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   opd_q;      // multiplicand (MUL*) or divisor (DIV*/REM*) magnitude
    logic [2*XLEN-1:0] prod_q;     // MUL*: {partial hi, multiplier}; DIV*: {remainder, dividend/quotient}
    logic [CW-1:0]     cnt_q;
    logic              neg_q;      // product / quotient must be negated
    logic              rneg_q;     // remainder must be negated (dividend was negative)
    logic [XLEN-1:0]   result_q;
    logic              out_valid_q;

    // ------------------------------------------------------------------
    // PREP decode: signedness, magnitudes and special-case divides
    // ------------------------------------------------------------------
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic            div_zero, div_ovf, special_d;
    logic [XLEN-1:0] a_mag, b_mag, special_res_d;

    always_comb begin
        a_sgn = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
        b_sgn = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
        a_neg = a_sgn && a_q[XLEN-1];
        b_neg = b_sgn && b_q[XLEN-1];
        // |-2^(XLEN-1)| = 2^(XLEN-1) still fits an XLEN-bit unsigned magnitude
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;

        div_zero  = (b_q == '0);
        div_ovf   = !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);
        special_d = op_q[2] && (div_zero || div_ovf);

        special_res_d = '0;
        if (div_zero) begin
            special_res_d = op_q[1] ? a_q : '1;
        end else begin
            special_res_d = op_q[1] ? '0 : a_q;
        end
    end

    // ------------------------------------------------------------------
    // CALC step: BITS_PER_CYCLE iterations of shift-add or restoring divide
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] step_d;
    logic [XLEN:0]     sum, mc, t;
    logic              qb;

    always_comb begin
        step_d = prod_q;
        sum    = '0;
        mc     = '0;
        t      = '0;
        qb     = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (!op_q[2]) begin
                // Multiply: add multiplicand into the high half when the multiplier LSB is set,
                // then shift right, keeping the carry as the new top bit.
                mc     = step_d[0] ? {1'b0, opd_q} : '0;
                sum    = {1'b0, step_d[2*XLEN-1:XLEN]} + mc;
                step_d = {sum, step_d[XLEN-1:1]};
            end else begin
                // Restoring divide: shift the next dividend bit into the remainder, try subtract.
                t = {step_d[2*XLEN-1:XLEN], step_d[XLEN-1]};
                if (t >= {1'b0, opd_q}) begin
                    t  = t - {1'b0, opd_q};
                    qb = 1'b1;
                end else begin
                    qb = 1'b0;
                end
                step_d = {t[XLEN-1:0], step_d[XLEN-2:0], qb};
            end
        end
    end

    // ------------------------------------------------------------------
    // FIX: sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] full;
    logic [XLEN-1:0]   quo, rem, fix_d;

    always_comb begin
        full  = neg_q ? -prod_q : prod_q;
        quo   = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem   = rneg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        fix_d = '0;
        if (op_q[2]) begin
            fix_d = op_q[1] ? rem : quo;
        end else begin
            fix_d = (op_q == 3'b000) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            opd_q       <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush && (state_q != S_IDLE)) begin
            // Abort; in DONE with out_ready the consumer still takes this cycle's result.
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_valid_q <= 1'b0;
                    if (in_valid && !flush) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_q  <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    if (special_d) begin
                        result_q    <= special_res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        prod_q  <= op_q[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                        opd_q   <= op_q[2] ? b_mag : a_mag;
                        cnt_q   <= CW'(STEPS - 1);
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    prod_q <= step_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    result_q    <= fix_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed XLEN=32/BPC=1 scenarios plus a random XLEN=16/BPC=4 run.
// Latency is counted in cycles after the request cycle (accept cycle = 0).
// Expected results come from a 64-bit reference model via a scoreboard queue.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit, 1 bit/cycle instance
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] a, b, result;

    // 16-bit, 4 bits/cycle instance
    logic        in_valid16, in_ready16, flush16, out_valid16, out_ready16, busy16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, result16;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    muldiv_unit #(.XLEN(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
        .a(a16), .b(b16), .flush(flush16), .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .busy(busy16)
    );

    int errors = 0;
    int checks = 0;
    localparam int LIMIT = 200;

    logic [31:0] sb_q[$];
    logic [15:0] sb16_q[$];

    function automatic logic [31:0] ref_model(input int xl, input logic [2:0] o,
                                              input logic [31:0] x, input logic [31:0] y);
        logic [63:0] mask, ux, uy, up, r;
        logic signed [63:0] sx, sy, sp, minv;
        mask = (64'd1 << xl) - 64'd1;
        ux   = {32'd0, x} & mask;
        uy   = {32'd0, y} & mask;
        sx   = x[xl-1] ? $signed(ux - (64'd1 << xl)) : $signed(ux);
        sy   = y[xl-1] ? $signed(uy - (64'd1 << xl)) : $signed(uy);
        minv = -$signed(64'd1 << (xl - 1));
        r    = 64'd0;
        case (o)
            3'b000: r = ux * uy;
            3'b001: begin sp = sx * sy;          r = sp >>> xl; end
            3'b010: begin sp = sx * $signed(uy); r = sp >>> xl; end
            3'b011: begin up = ux * uy;          r = up >> xl;  end
            3'b100: if (uy == 0) r = mask; else if (sx == minv && sy == -1) r = ux; else r = sx / sy;
            3'b101: if (uy == 0) r = mask; else r = ux / uy;
            3'b110: if (uy == 0) r = ux;   else if (sx == minv && sy == -1) r = 64'd0; else r = sx % sy;
            default: if (uy == 0) r = ux;  else r = ux % uy;
        endcase
        return 32'(r & mask);
    endfunction

    // One request on the 32-bit unit with out_ready held high; checks latency and result.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int exp_lat, input string name);
        int lat;
        logic [31:0] exp;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1; op = o; a = x; b = y;
        sb_q.push_back(ref_model(32, o, x, y));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid not seen within %0d cycles", name, LIMIT);
            sb_q.delete();
        end else begin
            exp = sb_q.pop_front();
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
            end
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL %s result: got %h want %h", name, result, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        in_valid16 = 1'b0; flush16 = 1'b0; out_ready16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        if (result !== 32'd0)   begin errors++; $display("FAIL reset result: got %h want 0", result); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset idle: in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_mul();
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, "mulhu_max");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 35, "mulh_min");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, "mulhsu_m1");
        run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 35, "mul_7_m3");
        run_op(3'b001, 32'h1234_5678, 32'hFEDC_BA98, 35, "mulh_mixed");
    endtask

    task automatic test_div();
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 35, "div_m7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 35, "rem_m7_2");
        run_op(3'b101, 32'd64,        32'd7, 35, "divu_64_7");
        run_op(3'b111, 32'd64,        32'd7, 35, "remu_64_7");
        run_op(3'b110, 32'd7,         32'hFFFF_FFFE, 35, "rem_7_m2");
    endtask

    task automatic test_special_div();
        run_op(3'b100, 32'd5,         32'd0,         2, "div_by_zero");
        run_op(3'b110, 32'd5,         32'd0,         2, "rem_by_zero");
        run_op(3'b101, 32'h8000_0001, 32'd0,         2, "divu_by_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 2, "div_overflow");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 2, "rem_overflow");
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 35, "divu_no_ovf");
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] exp;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b000; a = 32'd7; b = 32'hFFFF_FFFD;
        sb_q.push_back(ref_model(32, 3'b000, 32'd7, 32'hFFFF_FFFD));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < LIMIT) begin @(negedge clk); lat++; end
        exp = sb_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL hold out_valid cyc %0d: got %b want 1", i, out_valid); end
            if (result !== exp)     begin errors++; $display("FAIL hold result cyc %0d: got %h want %h", i, result, exp); end
            if (in_ready !== 1'b0)  begin errors++; $display("FAIL hold in_ready cyc %0d: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  vo[3] = '{3'b011, 3'b100, 3'b000};
        logic [31:0] va[3] = '{32'hDEAD_BEEF, 32'h8765_4321, 32'h0001_0003};
        logic [31:0] vb[3] = '{32'h1234_5678, 32'd13,        32'h0002_0005};
        int acc_cyc[3];
        int n_acc = 0, n_done = 0, cyc = 0;
        logic took, seen;
        logic [31:0] exp;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; op = vo[0]; a = va[0]; b = vb[0];
        while (n_done < 3 && cyc < 400) begin
            took = 1'b0;
            if (out_valid === 1'b1) begin
                exp = sb_q.pop_front();
                checks++;
                if (result !== exp) begin
                    errors++;
                    $display("FAIL b2b result %0d: got %h want %h", n_done, result, exp);
                end
                n_done++;
            end
            if (in_valid && in_ready === 1'b1) begin
                sb_q.push_back(ref_model(32, op, a, b));
                acc_cyc[n_acc] = cyc;
                n_acc++;
                took = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (took) begin
                if (n_acc < 3) begin op = vo[n_acc]; a = va[n_acc]; b = vb[n_acc]; end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        seen = (n_done == 3);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b timeout: completed %0d of 3", n_done);
            sb_q.delete();
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != 36) begin
                    errors++;
                    $display("FAIL b2b interval %0d: got %0d want 36", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic seen;
        // flush mid-CALC
        @(negedge clk);
        in_valid = 1'b1; op = 3'b101; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks += 3;
        if (busy !== 1'b0)      begin errors++; $display("FAIL flush_calc busy: got %b want 0", busy); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_calc in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_calc out_valid: got %b want 0", out_valid); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_calc pulse: got out_valid=1 want none"); end

        // flush together with an accept drops the request
        in_valid = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_accept: busy=%b in_ready=%b want 0/1", busy, in_ready);
        end

        // flush in DONE with out_ready: result handed over, then IDLE
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b100; a = 32'd9; b = 32'd0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL flush_done result: valid=%b result=%h want 1/ffffffff", out_valid, result);
        end
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_done idle: out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
    endtask

    task automatic test_async_reset();
        run_op(3'b101, 32'd100, 32'd7, 35, "pre_reset");
        @(negedge clk);
        in_valid = 1'b1; op = 3'b011; a = 32'hFFFF_FFFF; b = 32'h0000_0003;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL arst in_ready: got %b want 1", in_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL arst busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL arst out_valid: got %b want 0", out_valid); end
        if (result !== 32'd0)   begin errors++; $display("FAIL arst result: got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b000, 32'd12345, 32'd678, 35, "post_reset");
    endtask

    // Random run on the 16-bit, 4 bits/cycle instance with random result backpressure.
    task automatic test_random16();
        logic [2:0]  o;
        logic [15:0] x, y, exp;
        logic [15:0] corners[5] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
        int lat, exp_lat, hold;
        for (int n = 0; n < 150; n++) begin
            o = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            exp_lat = (o[2] && (y == 16'h0000 || (!o[0] && x == 16'h8000 && y == 16'hFFFF))) ? 2 : 7;
            @(negedge clk);
            in_valid16 = 1'b1; op16 = o; a16 = x; b16 = y;
            sb16_q.push_back(16'(ref_model(16, o, {16'd0, x}, {16'd0, y})));
            @(negedge clk);
            in_valid16 = 1'b0;
            lat = 1;
            while (out_valid16 !== 1'b1 && lat < LIMIT) begin @(negedge clk); lat++; end
            checks++;
            if (out_valid16 !== 1'b1) begin
                errors++;
                $display("FAIL rnd16 %0d timeout: no out_valid in %0d cycles", n, LIMIT);
                sb16_q.delete();
            end else begin
                exp = sb16_q.pop_front();
                checks += 2;
                if (lat != exp_lat) begin
                    errors++;
                    $display("FAIL rnd16 %0d latency op=%0d: got %0d want %0d", n, o, lat, exp_lat);
                end
                hold = $urandom_range(0, 2);
                repeat (hold) @(negedge clk);
                if (result16 !== exp) begin
                    errors++;
                    $display("FAIL rnd16 %0d op=%0d a=%h b=%h: got %h want %h", n, o, x, y, result16, exp);
                end
                out_ready16 = 1'b1;
                @(negedge clk);
                out_ready16 = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special_div();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
